// File: rtl/draw_pkg.sv
// Shared types and constants for the drawing-engine arbiter and the
// VGA pixel path it drives.
package draw_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   localparam logic [C_W-1:0] WHITE = 3'b111;
   localparam logic [C_W-1:0] BLACK = 3'b000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from last+1 upward with wrap and
// returns the first requester as one-hot plus index.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      any   = |req;
      // k runs 1..N so the previous winner is considered last.
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(last) + k) % N]) begin
            found = 1'b1;
            gnt[(int'(last) + k) % N] = 1'b1;
            idx = IW'((int'(last) + k) % N);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Grants the single VGA pixel write port to one drawing engine at a time and
// forwards that engine's pixels to the adapter with a two-cycle latency.
module draw_arbiter
   import draw_pkg::*;
#(
   parameter int N    = 3,
   parameter int WDOG = 20000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     done,
   input  logic [X_W*N-1:0] px_x,
   input  logic [Y_W*N-1:0] px_y,
   input  logic [C_W*N-1:0] px_color,
   output logic [N-1:0]     draw,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [C_W-1:0]   vga_color,
   output logic             vga_plot,
   output logic             busy,
   output logic             wdog_err,
   output arb_state_t       state_dbg
);

   localparam int IW = $clog2(N);
   localparam int WW = $clog2(WDOG + 1);

   arb_state_t    state, state_nxt;
   logic [N-1:0]  gnt;
   logic [IW-1:0] src;
   logic [IW-1:0] last;
   logic [WW-1:0] wcnt;
   logic [N-1:0]  done_q;
   logic [N-1:0]  done_rise;
   logic          wdog_hit;
   logic          vld_q;
   logic [IW-1:0] src_q;

   logic [N-1:0]  p_gnt;
   logic [IW-1:0] p_idx;
   logic          p_any;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req  (req),
      .last (last),
      .gnt  (p_gnt),
      .idx  (p_idx),
      .any  (p_any)
   );

   // A done level already high when the grant starts is not a rise.
   assign done_rise = done & ~done_q;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      draw      = '0;
      wdog_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (p_any) state_nxt = GRANT;
         end
         GRANT: begin
            // Drop draw in the completion cycle so the engine does not restart.
            draw = gnt & ~done_rise;
            if (done_rise[src]) begin
               state_nxt = RELEASE;
            end else if (wcnt == WW'(WDOG - 1)) begin
               state_nxt = RELEASE;
               wdog_hit  = 1'b1;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt      <= '0;
         src      <= '0;
         last     <= IW'(N - 1);
         wcnt     <= '0;
         done_q   <= '0;
         wdog_err <= 1'b0;
      end else begin
         done_q <= done;
         case (state)
            IDLE: begin
               if (p_any) begin
                  gnt  <= p_gnt;
                  src  <= p_idx;
                  wcnt <= '0;
               end
            end
            GRANT: begin
               wcnt <= wcnt + 1'b1;
               if (state_nxt == RELEASE) begin
                  last <= src;
                  gnt  <= '0;
               end
               if (wdog_hit) wdog_err <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Pixel pipe: draw in cycle k -> engine updates px after k+1 -> plot after k+2.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q     <= 1'b0;
         src_q     <= '0;
         vga_plot  <= 1'b0;
         vga_x     <= '0;
         vga_y     <= '0;
         vga_color <= BLACK;
      end else begin
         vld_q    <= |draw;
         src_q    <= src;
         vga_plot <= vld_q;
         if (vld_q) begin
            vga_x     <= px_x[X_W*src_q +: X_W];
            vga_y     <= px_y[Y_W*src_q +: Y_W];
            vga_color <= px_color[C_W*src_q +: C_W];
         end
      end
   end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single VGA-adapter pixel write port among N drawing engines (screen clear, sprite, text banners such as the game-over screen). Each engine raises a request, is granted exclusive use of the port, streams pixels through the arbiter while `draw` is held, and is released when it signals completion. The arbiter sits between the drawing engines and the VGA adapter. It owns `vga_x/vga_y/vga_color/vga_plot`.

## Interface
- `N`, 3: number of drawing engines (2..8)
- `WDOG`, 20000: maximum cycles one grant may last before forced release
- `clock`  in  1: system clock, all logic on rising edge
- `reset`  in  1: asynchronous, active-high; clears all state
- `req`  in  N: engine i wants the port (level)
- `done`  in  N: engine i `finish_drawing` level; completion is its rising edge
- `px_x`  in  8·N: engine i x at bits [8i+7:8i]
- `px_y`  in  7·N: engine i y at bits [7i+6:7i]
- `px_color`  in  3·N: engine i color at bits [3i+2:3i]
- `draw`  out  N: one-hot enable to the granted engine
- `vga_x`  out  8, `vga_y`  out  7, `vga_color`  out  3: registered pixel to the adapter
- `vga_plot`  out  1: registered write strobe
- `busy`  out  1: high in GRANT or RELEASE
- `wdog_err`  out  1: sticky; set by a forced release, cleared only by reset

## Operation
- States: IDLE, GRANT, RELEASE.
- **IDLE:** if `req != 0`, pick the winner round-robin: search starts at `last+1` mod N, lowest index first after wrap. Store it as one-hot `gnt` and index `src`, then go to GRANT. `last` resets to N-1, so engine 0 wins first.
- **GRANT:**
  - `draw[i] = gnt[i] & ~done_rise[i]`, combinational.
  - `done_q` registers `done` every cycle. `done_rise = done & ~done_q`.
  - A stale high `done` left from an engine's previous run is not a rise and is ignored.
  - On `done_rise[src]`: go to RELEASE and set `last = src`. `draw` is already low in that cycle, so the engine does not restart.
  - A `done_rise` on a non-granted engine is ignored.
  - A drop of `req[src]` during GRANT is ignored. The grant is held until completion.
- **Watchdog:**
  - `wcnt` clears on entry to GRANT and increments each GRANT cycle.
  - At `wcnt == WDOG-1`, go to RELEASE with `last = src` and set `wdog_err`.
- **RELEASE:** one cycle. `draw` is all zero. Then go to IDLE. This guarantees at least one dead cycle between grants.
- **Pixel path:**
  - `vld_q <= |draw` and `src_q <= src` each cycle.
  - Then `vga_plot <= vld_q`. The slices `vga_x/vga_y/vga_color` at `src_q` are registered at the same time as `vga_plot`.
  - The adapter samples `vga_*` only when `vga_plot` is high. Otherwise hold their last values.
- **Reset** (async, any state): state = IDLE, `gnt = 0`, `last = N-1`, `wcnt = 0`, `done_q = 0`, `vld_q = 0`, `wdog_err = 0`. Outputs: `draw = 0`, `vga_x = 0`, `vga_y = 0`, `vga_color = 0`, `vga_plot = 0`, `busy = 0`.
- Reset mid-grant abandons the transfer. No pixel is emitted after reset asserts.

## Timing
- Request sampled in IDLE at edge t → GRANT from t+1 → `draw` high during cycle t+1.
- Engine pixel for `draw` high in cycle k appears on `px_*` after edge k+1. It appears on `vga_*` with `vga_plot` after edge k+2. Latency is 2 cycles from `draw` to plot.
- Last pixel:
  - The engine updates the last pixel and raises `done` on the same edge.
  - `draw` drops in that cycle.
  - `vld_q` from the preceding high `draw` still carries that last pixel out.
- Back-to-back requesters: minimum 3 non-drawing cycles between the last `draw` of one engine and the first `draw` of the next (done cycle, RELEASE, IDLE).
- `req` set in the same cycle another grant completes waits for the next IDLE.

## Structure
- Package `draw_pkg`:
  - `X_W=8`, `Y_W=7`, `C_W=3`.
  - `arb_state_t` enum {IDLE, GRANT, RELEASE}.
  - Colour constants `WHITE=3'b111`, `BLACK=3'b000`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req[N]`, `last`. Outputs one-hot `gnt`, index, and `any`. Reused by future resource arbiters.

## Test plan
- Reset with `req=3'b111` → no `draw` or `vga_plot` during reset; after release, engine 0 granted first. `vga_x/vga_y/vga_color` = 0 until the first plot.
- Single engine drawing 35 pixels (x 130..134, y 100..106) then raising `done` → exactly 35 `vga_plot` pulses with matching coordinates, each 2 cycles after its `draw` cycle. `draw` drops the cycle `done` rises. No 36th pixel.
- Stale `done` high at grant start → engine still drawn, grant not released until `done` falls and rises again.
- All three requesting continuously → grant order 0,1,2,0,1,2. Each gap is ≥3 non-`draw` cycles.
- Engine never raises `done`, `WDOG=50` → release after 50 GRANT cycles, `wdog_err=1`, next requester granted; `wdog_err` persists until reset.
- Async `reset` pulse mid-grant between clock edges → `draw`, `vga_plot`, `busy` low immediately. After release, arbitration restarts at engine 0.
